spi_mstr16_ctrl: RTL and testbench



---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sclk_gen.sv | 58 +++++
 rtl/spi_mstr16_ctrl.sv | 113 +++++++++++
 tb/tb_spi_mstr16_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state type and frame-shape constants for the 16-bit SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } spi_state_e;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned FRONT_PORCH = 8;
    localparam int unsigned BACK_PORCH  = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: free-running count while a frame is active, registered SCLK
// (idle high) and single-cycle rise/fall pulses aligned with the SCLK update.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             start_i,
    output logic             sclk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [DIV_W-1:0] div_o
);

    localparam int unsigned      HALF      = 2 ** (DIV_W - 1);
    // Preloading the counter makes the first low half begin exactly FRONT_PORCH clk after start.
    localparam logic [DIV_W-1:0] START_CNT = DIV_W'(HALF - FRONT_PORCH);
    localparam logic [DIV_W-1:0] FALL_CNT  = DIV_W'(HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;

    assign fall_o = en_i && (div_q == FALL_CNT);
    assign rise_o = en_i && (div_q == '1);
    assign sclk_o = sclk_q;
    assign div_o  = div_q;

    always_comb begin
        div_d  = '0;
        sclk_d = 1'b1;
        if (start_i) begin
            div_d = START_CNT;
        end else if (en_i) begin
            div_d = div_q + DIV_W'(1);
            if (fall_o) begin
                sclk_d = 1'b0;
            end else if (rise_o) begin
                sclk_d = 1'b1;
            end else begin
                sclk_d = sclk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_mstr16_ctrl.sv
// 16-bit full-duplex SPI master: one wrt strobe runs one framed transfer.
// Build option SPI_MSTR16_LOOPBACK_EN receives the internal MOSI instead of MISO.
module spi_mstr16_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        MOSI,
    output logic        SS_n,
    output logic        SCLK,
    output logic        done,
    output logic [15:0] rd_data
);

    spi_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic                  ss_n_q, ss_n_d;
    logic                  done_q, done_d;
    logic                  start, rise, fall, rx_bit;
    logic [DIV_W-1:0]      div;

    assign start = (state_q == IDLE) && wrt;

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q != IDLE),
        .start_i (start),
        .sclk_o  (SCLK),
        .rise_o  (rise),
        .fall_o  (fall),
        .div_o   (div)
    );

`ifdef SPI_MSTR16_LOOPBACK_EN
    assign rx_bit = tx_q[FRAME_BITS-1];
`else
    assign rx_bit = MISO;
`endif

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        ss_n_d    = ss_n_q;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                if (wrt) begin
                    tx_d      = cmd;
                    bit_cnt_d = '0;
                    ss_n_d    = 1'b0;
                    done_d    = 1'b0;
                    state_d   = FRONT;
                end
            end
            FRONT: begin
                if (fall) state_d = SHIFT;
            end
            SHIFT: begin
                // The MSB is already on MOSI from SS_n fall, so the first fall does not shift.
                if (fall && (bit_cnt_q[3:0] != '0)) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
                if (rise) begin
                    rx_d      = {rx_q[FRAME_BITS-2:0], rx_bit};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_d[4]) state_d = BACK;
                end
            end
            BACK: begin
                if (div == DIV_W'(BACK_PORCH - 1)) begin
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            ss_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            ss_n_q    <= ss_n_d;
            done_q    <= done_d;
        end
    end

    assign MOSI    = tx_q[FRAME_BITS-1];
    assign SS_n    = ss_n_q;
    assign done    = done_q;
    assign rd_data = rx_q;

endmodule

// File: tb/tb_spi_mstr16_ctrl.sv
// Bench for spi_mstr16_ctrl: cycle-level frame-timing model plus an ADC128S-style
// slave that returns each programmed word one frame late.
module tb_spi_mstr16_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] cmd = '0;
    logic        MISO = 1'b0;
    logic        MOSI, SS_n, SCLK, done;
    logic [15:0] rd_data;

    spi_mstr16_ctrl #(.DIV_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .MOSI    (MOSI),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .done    (done),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC slave: on SS_n fall presents the previously programmed word, MSB first,
    // advancing one bit on every SCLK fall after the first.
    logic [15:0] adc_next = '0;
    logic [15:0] adc_pend = '0;
    logic [15:0] adc_sr   = '0;
    int          adc_falls = 0;
    logic        adc_ss_prev = 1'b1;
    logic        adc_sclk_prev = 1'b1;

    always @(SS_n or SCLK) begin
        if (adc_ss_prev === 1'b1 && SS_n === 1'b0) begin
            adc_sr    = adc_pend;
            adc_pend  = adc_next;
            adc_falls = 0;
            MISO      = adc_sr[15];
        end else if (SS_n === 1'b0 && adc_sclk_prev === 1'b1 && SCLK === 1'b0) begin
            if (adc_falls > 0) adc_sr = {adc_sr[14:0], 1'b0};
            adc_falls++;
            MISO = adc_sr[15];
        end
        adc_ss_prev   = SS_n;
        adc_sclk_prev = SCLK;
    end

    // Reference model: a frame accepted at edge E0 occupies edges E0..E512;
    // n counts cycles since E0 (n=1 is the cycle SS_n goes low).
    bit          m_check = 0, m_busy = 0, m_done = 0, m_rd_known = 0;
    int          m_start = 0;
    logic [15:0] m_cmd = '0, m_rd = '0, m_pend = '0;
    logic        m_mosi_idle = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_check = 1; m_busy = 0; m_done = 0;
            m_rd = '0; m_rd_known = 1; m_mosi_idle = 1'b0;
        end else if (m_busy && (cyc - m_start) == 512) begin
            m_busy = 0; m_done = 1; m_rd_known = 1; m_mosi_idle = m_cmd[0];
        end else if (!m_busy && wrt) begin
            m_busy = 1; m_start = cyc; m_cmd = cmd; m_done = 0; m_rd_known = 0;
`ifdef SPI_MSTR16_LOOPBACK_EN
            m_rd = cmd;
`else
            m_rd = m_pend;
`endif
            m_pend = adc_next;
        end
        cyc++;
    end

    int   n, k;
    logic e_ss, e_sclk, e_mosi;

    always @(negedge clk) begin
        if (m_check) begin
            n      = cyc - m_start;
            e_ss   = m_busy ? 1'b0 : 1'b1;
            e_sclk = (m_busy && n >= 9 && n <= 504 && ((n - 9) % 32) < 16) ? 1'b0 : 1'b1;
            k      = (n < 9) ? 0 : (n - 9) / 32;
            if (k > 15) k = 15;
            e_mosi = m_busy ? m_cmd[15 - k] : m_mosi_idle;
            check("SS_n", {15'd0, SS_n}, {15'd0, e_ss});
            check("SCLK", {15'd0, SCLK}, {15'd0, e_sclk});
            check("MOSI", {15'd0, MOSI}, {15'd0, e_mosi});
            check("done", {15'd0, done}, {15'd0, m_done});
            if (!m_busy && m_rd_known) check("rd_data", rd_data, m_rd);
        end
    end

    // Directed frame driver; records pin-level timing relative to the wrt cycle.
    int          r_low, r_fall, r_rises, r_done_at;
    logic [15:0] r_bits;
    logic        r_ab_ss, r_ab_sclk, r_ab_done;

    task automatic run_frame(input logic [15:0] c, input int busy_j, input int rst_j);
        logic prev_sclk;
        r_low = 0; r_fall = 0; r_rises = 0; r_done_at = 0; r_bits = '0;
        r_ab_ss = 1'bx; r_ab_sclk = 1'bx; r_ab_done = 1'bx;
        prev_sclk = 1'b1;
        @(negedge clk);
        cmd = c;
        wrt = 1'b1;
        for (int j = 1; j <= 520; j++) begin
            @(negedge clk);
            wrt = 1'b0;
            if (j == busy_j) begin
                wrt = 1'b1;
                cmd = ~c;
            end
            rst = (j == rst_j);
            if (SS_n === 1'b0 && r_low == 0) r_low = j;
            if (SCLK === 1'b0 && r_fall == 0) r_fall = j;
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
                r_rises++;
                r_bits = {r_bits[14:0], MOSI};
            end
            prev_sclk = SCLK;
            if (done === 1'b1 && r_done_at == 0) r_done_at = j;
            if (rst_j > 0 && j == rst_j + 1) begin
                r_ab_ss = SS_n; r_ab_sclk = SCLK; r_ab_done = done;
            end
            if (r_done_at != 0 || (rst_j > 0 && j > rst_j + 1)) break;
        end
        wrt = 1'b0;
        rst = 1'b0;
    endtask

    task automatic check_full_frame(input string tag, input logic [15:0] c);
        check({tag, "_ss_fall"}, 16'(r_low), 16'd1);
        check({tag, "_first_sclk_fall"}, 16'(r_fall), 16'd9);
        check({tag, "_rises"}, 16'(r_rises), 16'd16);
        check({tag, "_mosi_stream"}, r_bits, c);
        check({tag, "_done_at"}, 16'(r_done_at), 16'd513);
    endtask

    logic [15:0] rc, expv;
    int          mode, pos;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_SS_n", {15'd0, SS_n}, 16'd1);
        check("rst_SCLK", {15'd0, SCLK}, 16'd1);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_rd_data", rd_data, 16'h0000);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_SS_n", {15'd0, SS_n}, 16'd1);
        check("idle_SCLK", {15'd0, SCLK}, 16'd1);
        check("idle_rd_data", rd_data, 16'h0000);

        run_frame(16'hA55A, 0, 0);
        check_full_frame("a55a", 16'hA55A);
        check("a55a_literal_bits", r_bits, 16'b1010010101011010);
        check("a55a_ss_at_done", {15'd0, SS_n}, 16'd1);

        run_frame(16'h3C96, 100, 0);
        check_full_frame("busy", 16'h3C96);

        run_frame(16'h5A5A, 0, 200);
        check("abort_SS_n", {15'd0, r_ab_ss}, 16'd1);
        check("abort_SCLK", {15'd0, r_ab_sclk}, 16'd1);
        check("abort_done", {15'd0, r_ab_done}, 16'd0);
        check("abort_no_done", 16'(r_done_at), 16'd0);
        run_frame(16'hC3E1, 0, 0);
        check_full_frame("post_abort", 16'hC3E1);

`ifdef SPI_MSTR16_LOOPBACK_EN
        run_frame(16'h1234, 0, 0);
        check("loopback_rd", rd_data, 16'h1234);
`endif

        // ADC read loop: each frame returns the level programmed before the previous frame.
        for (int i = 0; i < 100; i += 2) begin
            adc_next = 16'h0C00 - 16'(i * 16);
            run_frame(16'h0000, 0, 0);
            if (i > 0) begin
`ifdef SPI_MSTR16_LOOPBACK_EN
                check("adc_rd", rd_data, 16'h0000);
`else
                check("adc_rd", rd_data, 16'h0C00 - 16'((i - 2) * 16));
`endif
            end
        end
        run_frame(16'h0000, 0, 0);
`ifdef SPI_MSTR16_LOOPBACK_EN
        check("adc_rd_last", rd_data, 16'h0000);
`else
        check("adc_rd_last", rd_data, 16'h0C00 - 16'(98 * 16));
`endif

        // Random frames, busy writes and mid-frame resets; the model checks every cycle.
        for (int r = 0; r < 14; r++) begin
            rc       = 16'($urandom);
            adc_next = 16'($urandom);
            mode     = int'($urandom_range(0, 2));
            pos      = int'($urandom_range(2, 510));
            if (mode == 1) run_frame(rc, pos, 0);
            else if (mode == 2) run_frame(rc, 0, pos);
            else run_frame(rc, 0, 0);
            if (mode != 2) begin
                expv = rc;
                check("rand_mosi_stream", r_bits, expv);
                check("rand_done_at", 16'(r_done_at), 16'd513);
            end else begin
                check("rand_abort_no_done", 16'(r_done_at), 16'd0);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
